// File: rtl/regfile_pkg.sv
// regfile_pkg: parameters and types shared by the register-file request arbiter.
//   DATA_W / ADDR_W : default data and index widths.
//   NUM_RD / NUM_WR : reader and writer source counts.
//   src_e           : source index, in arbitration order rd0..rd3, wr0, wr1.
package regfile_pkg;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int NUM_RD  = 4;
  localparam int NUM_WR  = 2;
  localparam int NUM_SRC = NUM_RD + NUM_WR;

  typedef enum logic [2:0] {
    SRC_RD0 = 3'd0,
    SRC_RD1 = 3'd1,
    SRC_RD2 = 3'd2,
    SRC_RD3 = 3'd3,
    SRC_WR0 = 3'd4,
    SRC_WR1 = 3'd5
  } src_e;

  // Next source in arbitration order, wrapping wr1 back to rd0.
  function automatic logic [2:0] next_src(input logic [2:0] s);
    if (s == SRC_WR1) begin
      return SRC_RD0;
    end else begin
      return s + 3'd1;
    end
  endfunction
endpackage

// File: rtl/regfile_req_arb_if.sv
// regfile_req_arb_if: request/response and register-file bus of the arbiter.
//   Requester side : rd_req_*, wr_req_* (valid/ready), rd_rsp_* (no backpressure).
//   Register side  : rf_read/rf_write one-hot enables, packed indices/data, rf_out.
//   Modports       : slave = arbiter, master = requesters plus register file.
interface regfile_req_arb_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic [3:0]          rd_req_valid;
  logic [4*ADDR_W-1:0] rd_req_addr;
  logic [3:0]          rd_req_ready;
  logic [1:0]          wr_req_valid;
  logic [2*ADDR_W-1:0] wr_req_addr;
  logic [2*DATA_W-1:0] wr_req_data;
  logic [1:0]          wr_req_ready;
  logic [3:0]          rd_rsp_valid;
  logic [DATA_W-1:0]   rd_rsp_data;
  logic [3:0]          rf_read;
  logic [1:0]          rf_write;
  logic [4*ADDR_W-1:0] rf_rd_addr;
  logic [2*ADDR_W-1:0] rf_wr_addr;
  logic [2*DATA_W-1:0] rf_wr_data;
  logic [DATA_W-1:0]   rf_out;

  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, rf_out,
    output rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_data,
           rf_read, rf_write, rf_rd_addr, rf_wr_addr, rf_wr_data
  );

  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, rf_out,
    input  rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_data,
           rf_read, rf_write, rf_rd_addr, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/regfile_rr_arbiter.sv
// regfile_rr_arbiter: 6-way arbiter over the pending slots.
//   clk, rst : clock, asynchronous active-high reset.
//   req      : pending vector in source order rd0..rd3, wr0, wr1.
//   grant    : one-hot grant (zero when nothing is pending).
// Macro REGFILE_ARB_RR_EN selects round-robin (pointer moves past the winner);
// without it the pointer is pinned at rd0, which makes the search fixed priority.
module regfile_rr_arbiter
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant
);
  logic [2:0] ptr_r;
  logic [2:0] ptr_nxt_s;
  logic [2:0] idx_s;
  logic       found_s;

  // Circular search from the pointer; the first pending source wins.
  always_comb begin
    grant     = {NUM_SRC{1'b0}};
    found_s   = 1'b0;
    ptr_nxt_s = ptr_r;
    idx_s     = ptr_r;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
`ifdef REGFILE_ARB_RR_EN
        ptr_nxt_s    = next_src(idx_s);
`else
        ptr_nxt_s    = SRC_RD0;
`endif
      end else begin
        found_s = found_s;
      end
      idx_s = next_src(idx_s);
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= SRC_RD0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end
endmodule

// File: rtl/regfile_req_arb.sv
// regfile_req_arb: arbitrates 4 readers and 2 writers onto one register-file
// command per cycle.
//   clk, rst : clock, asynchronous active-high reset.
//   bus      : slave modport of regfile_req_arb_if (requests, responses, rf_*).
// Each source owns one pending slot; a granted slot can refill in the same cycle.
// A read granted at edge E drives rf_read after E, the file samples at E+1,
// rf_out is valid after E+2 and is returned with a one-cycle rd_rsp_valid pulse.
// Optional macro REGFILE_ARB_RR_EN (in regfile_rr_arbiter) enables round-robin.
module regfile_req_arb #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input logic              clk,
  input logic              rst,
  regfile_req_arb_if.slave bus
);
  import regfile_pkg::*;

  localparam int WR_BASE = int'(SRC_WR0);

  logic [NUM_SRC-1:0]       req_s, grant_s, ready_s, acc_s, pend_r;
  logic [ADDR_W-1:0]        req_addr_s  [NUM_SRC];
  logic [ADDR_W-1:0]        slot_addr_r [NUM_SRC];
  logic [DATA_W-1:0]        slot_data_r [NUM_WR];
  logic [NUM_RD-1:0]        rf_read_r, rsp_v2_r, rsp_valid_r;
  logic [NUM_WR-1:0]        rf_write_r;
  logic [NUM_RD*ADDR_W-1:0] rf_rd_addr_r;
  logic [NUM_WR*ADDR_W-1:0] rf_wr_addr_r;
  logic [NUM_WR*DATA_W-1:0] rf_wr_data_r;

  // Gather request valids and indices into source order.
  always_comb begin
    req_s = {bus.wr_req_valid, bus.rd_req_valid};
    for (int i = 0; i < NUM_RD; i++) begin
      req_addr_s[i] = bus.rd_req_addr[i*ADDR_W +: ADDR_W];
    end
    for (int j = 0; j < NUM_WR; j++) begin
      req_addr_s[WR_BASE+j] = bus.wr_req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  regfile_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (pend_r),
    .grant (grant_s)
  );

  // Ready when the slot is free or is being drained this cycle; held low in reset.
  always_comb begin
    if (rst) begin
      ready_s = {NUM_SRC{1'b0}};
    end else begin
      ready_s = ~pend_r | grant_s;
    end
    acc_s = req_s & ready_s;
  end

  // Pending slots: an acceptance wins over the same-cycle grant (refill).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) slot_addr_r[i] <= {ADDR_W{1'b0}};
      for (int j = 0; j < NUM_WR; j++)  slot_data_r[j] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc_s[i]) begin
          pend_r[i]      <= 1'b1;
          slot_addr_r[i] <= req_addr_s[i];
        end else if (grant_s[i]) begin
          pend_r[i] <= 1'b0;
        end
      end
      for (int j = 0; j < NUM_WR; j++) begin
        if (acc_s[WR_BASE+j]) slot_data_r[j] <= bus.wr_req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Registered file command; only the granted source's fields are reloaded.
  // The two-stage tail after rf_read lines the response up with rf_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_read_r    <= {NUM_RD{1'b0}};
      rf_write_r   <= {NUM_WR{1'b0}};
      rf_rd_addr_r <= {(NUM_RD*ADDR_W){1'b0}};
      rf_wr_addr_r <= {(NUM_WR*ADDR_W){1'b0}};
      rf_wr_data_r <= {(NUM_WR*DATA_W){1'b0}};
      rsp_v2_r     <= {NUM_RD{1'b0}};
      rsp_valid_r  <= {NUM_RD{1'b0}};
    end else begin
      rf_read_r   <= grant_s[NUM_RD-1:0];
      rf_write_r  <= grant_s[NUM_SRC-1:WR_BASE];
      rsp_v2_r    <= rf_read_r;
      rsp_valid_r <= rsp_v2_r;
      for (int i = 0; i < NUM_RD; i++) begin
        if (grant_s[i]) rf_rd_addr_r[i*ADDR_W +: ADDR_W] <= slot_addr_r[i];
      end
      for (int j = 0; j < NUM_WR; j++) begin
        if (grant_s[WR_BASE+j]) begin
          rf_wr_addr_r[j*ADDR_W +: ADDR_W] <= slot_addr_r[WR_BASE+j];
          rf_wr_data_r[j*DATA_W +: DATA_W] <= slot_data_r[j];
        end
      end
    end
  end

  assign bus.rd_req_ready = ready_s[NUM_RD-1:0];
  assign bus.wr_req_ready = ready_s[NUM_SRC-1:WR_BASE];
  assign bus.rd_rsp_valid = rsp_valid_r;
  assign bus.rd_rsp_data  = bus.rf_out;
  assign bus.rf_read      = rf_read_r;
  assign bus.rf_write     = rf_write_r;
  assign bus.rf_rd_addr   = rf_rd_addr_r;
  assign bus.rf_wr_addr   = rf_wr_addr_r;
  assign bus.rf_wr_data   = rf_wr_data_r;
endmodule

// File: tb/tb_regfile_req_arb.sv
// tb_regfile_req_arb: self-checking bench for regfile_req_arb with a behavioural
// register file (sample at edge, data out after the next edge) and a response
// scoreboard holding expected {valid, data, cycle}.
module tb_regfile_req_arb;
  localparam int AW = regfile_pkg::ADDR_W;
  localparam int DW = regfile_pkg::DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_req_arb_if bus ();

  regfile_req_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural register file.
  logic [DW-1:0] mem [32] = '{default: 64'h0};
  logic [AW-1:0] lat = 5'd0;
  logic [DW-1:0] rf_out_m = 64'h0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (bus.rf_read[i]) lat <= bus.rf_rd_addr[i*AW +: AW];
    rf_out_m <= mem[lat];
    for (int j = 0; j < 2; j++) if (bus.rf_write[j]) mem[bus.rf_wr_addr[j*AW +: AW]] <= bus.rf_wr_data[j*DW +: DW];
  end
  assign bus.rf_out = rf_out_m;

  typedef struct packed {
    logic [3:0]    v;
    logic [DW-1:0] d;
    logic [31:0]   at;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int            src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    rf_rd;
    logic [1:0]    rf_wr;
    logic [DW-1:0] rdata;
  } vec_t;
  vec_t vecs[9];

  logic [4*AW-1:0] exp_rd_addr;
  logic [2*AW-1:0] exp_wr_addr;
  logic [2*DW-1:0] exp_wr_data;
  logic [5:0]      r6;
  int              acc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rd_req_valid = 4'b0;
    bus.rd_req_addr  = '0;
    bus.wr_req_valid = 2'b0;
    bus.wr_req_addr  = '0;
    bus.wr_req_data  = '0;
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_rd_addr"}, bus.rf_rd_addr, exp_rd_addr);
    check({tag, "_wr_addr"}, bus.rf_wr_addr, exp_wr_addr);
    check({tag, "_wr_data"}, bus.rf_wr_data, exp_wr_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    r6 = {bus.wr_req_ready, bus.rd_req_ready};
    check("rst_ready", r6, 6'b0);
    check("rst_cmd", {bus.rf_write, bus.rf_read}, 6'b0);
    check("rst_rsp", bus.rd_rsp_valid, 4'b0);
    tick();
    rst = 1'b0;
    exp_rd_addr = '0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
    #1;
    r6 = {bus.wr_req_ready, bus.rd_req_ready};
    check("post_rst_ready", r6, 6'b111111);
  endtask

  // Response scoreboard: every pulse must match the queue head in value and cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && int'(sbq[0].at) < cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing act=none exp=%b@%0d", e.v, e.at);
      end
      if (bus.rd_rsp_valid != 4'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected act=%b@%0d exp=none", bus.rd_rsp_valid, cyc);
        end else begin
          e = sbq.pop_front();
          check("rsp_valid", bus.rd_rsp_valid, e.v);
          check("rsp_data", bus.rd_rsp_data, e.d);
          check("rsp_cycle", cyc, e.at);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{src: 4, addr: 5'd5,  data: 64'hDEAD_BEEF,            rf_rd: 4'b0000, rf_wr: 2'b01, rdata: 64'h0};
    vecs[1] = '{src: 2, addr: 5'd5,  data: 64'h0,                    rf_rd: 4'b0100, rf_wr: 2'b00, rdata: 64'hDEAD_BEEF};
    vecs[2] = '{src: 5, addr: 5'd3,  data: 64'h0123_4567_89AB_CDEF,  rf_rd: 4'b0000, rf_wr: 2'b10, rdata: 64'h0};
    vecs[3] = '{src: 1, addr: 5'd3,  data: 64'h0,                    rf_rd: 4'b0010, rf_wr: 2'b00, rdata: 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{src: 0, addr: 5'd0,  data: 64'h0,                    rf_rd: 4'b0001, rf_wr: 2'b00, rdata: 64'h0};
    vecs[5] = '{src: 4, addr: 5'd31, data: 64'hFFFF_FFFF_FFFF_FFFF,  rf_rd: 4'b0000, rf_wr: 2'b01, rdata: 64'h0};
    vecs[6] = '{src: 3, addr: 5'd31, data: 64'h0,                    rf_rd: 4'b1000, rf_wr: 2'b00, rdata: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{src: 5, addr: 5'd0,  data: 64'h1,                    rf_rd: 4'b0000, rf_wr: 2'b10, rdata: 64'h0};
    vecs[8] = '{src: 0, addr: 5'd0,  data: 64'h0,                    rf_rd: 4'b0001, rf_wr: 2'b00, rdata: 64'h1};

    clear_inputs();
    fork
      monitor();
    join_none

    // Reset state.
    do_reset();
    check_fields("rst");

    // Single transactions, one at a time.
    for (int n = 0; n < 9; n++) begin
      if (vecs[n].src < 4) begin
        bus.rd_req_valid[vecs[n].src] = 1'b1;
        bus.rd_req_addr[vecs[n].src*AW +: AW] = vecs[n].addr;
      end else begin
        bus.wr_req_valid[vecs[n].src-4] = 1'b1;
        bus.wr_req_addr[(vecs[n].src-4)*AW +: AW] = vecs[n].addr;
        bus.wr_req_data[(vecs[n].src-4)*DW +: DW] = vecs[n].data;
      end
      #1;
      r6 = {bus.wr_req_ready, bus.rd_req_ready};
      check("vec_ready", r6[vecs[n].src], 1'b1);
      tick();
      acc = cyc;
      clear_inputs();
      if (vecs[n].src < 4) begin
        sbq.push_back('{v: vecs[n].rf_rd, d: vecs[n].rdata, at: 32'(acc + 3)});
        exp_rd_addr[vecs[n].src*AW +: AW] = vecs[n].addr;
      end else begin
        exp_wr_addr[(vecs[n].src-4)*AW +: AW] = vecs[n].addr;
        exp_wr_data[(vecs[n].src-4)*DW +: DW] = vecs[n].data;
      end
      tick();
      check("vec_cmd", {bus.rf_write, bus.rf_read}, {vecs[n].rf_wr, vecs[n].rf_rd});
      check_fields("vec");
      tick();
      check("vec_cmd_drop", {bus.rf_write, bus.rf_read}, 6'b0);
    end
    repeat (4) tick();

    // Idle: no commands, fields hold.
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_cmd", {bus.rf_write, bus.rf_read}, 6'b0);
      check_fields("idle");
    end

    // All six sources at once: grants one per cycle in source order.
    do_reset();
    bus.rd_req_valid = 4'b1111;
    bus.rd_req_addr  = {5'd0, 5'd31, 5'd3, 5'd5};
    bus.wr_req_valid = 2'b11;
    bus.wr_req_addr  = {5'd8, 5'd7};
    bus.wr_req_data  = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    tick();
    acc = cyc;
    clear_inputs();
    r6 = {bus.wr_req_ready, bus.rd_req_ready};
    check("all_ready_busy", r6, 6'b000001);
    sbq.push_back('{v: 4'b0001, d: 64'hDEAD_BEEF,           at: 32'(acc + 3)});
    sbq.push_back('{v: 4'b0010, d: 64'h0123_4567_89AB_CDEF, at: 32'(acc + 4)});
    sbq.push_back('{v: 4'b0100, d: 64'hFFFF_FFFF_FFFF_FFFF, at: 32'(acc + 5)});
    sbq.push_back('{v: 4'b1000, d: 64'h1,                   at: 32'(acc + 6)});
    for (int k = 0; k < 6; k++) begin
      tick();
      r6 = 6'b000001 << k;
      check("all_grant", {bus.rf_write, bus.rf_read}, r6);
    end
    exp_rd_addr = {5'd0, 5'd31, 5'd3, 5'd5};
    exp_wr_addr = {5'd8, 5'd7};
    exp_wr_data = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    tick();
    check("all_done", {bus.rf_write, bus.rf_read}, 6'b0);
    check_fields("all");
    repeat (4) tick();

    // rd1 streams addr 3 for 8 cycles: ready stays high, one response per cycle.
    bus.rd_req_valid[1] = 1'b1;
    bus.rd_req_addr[AW +: AW] = 5'd3;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("stream_ready", bus.rd_req_ready[1], 1'b1);
      tick();
      sbq.push_back('{v: 4'b0010, d: 64'h0123_4567_89AB_CDEF, at: 32'(cyc + 3)});
    end
    clear_inputs();
    exp_rd_addr[AW +: AW] = 5'd3;
    repeat (6) tick();
    check_fields("stream");

`ifdef REGFILE_ARB_RR_EN
    // Round-robin: rd0 held valid with rd1 -> grants alternate.
    do_reset();
    bus.rd_req_valid = 4'b0011;
    bus.rd_req_addr  = {5'd0, 5'd0, 5'd3, 5'd0};
    tick();
    acc = cyc;
    for (int k = 0; k < 5; k++) begin
      sbq.push_back('{v: (k % 2 == 0) ? 4'b0001 : 4'b0010,
                      d: (k % 2 == 0) ? 64'h1 : 64'h0123_4567_89AB_CDEF,
                      at: 32'(acc + 3 + k)});
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) clear_inputs();
      check("rr_grant", bus.rf_read, (k % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    tick();
    check("rr_done", bus.rf_read, 4'b0);
    repeat (4) tick();
`endif

    // Reset one cycle after a read grant: the response is dropped.
    bus.rd_req_valid[0] = 1'b1;
    bus.rd_req_addr[0 +: AW] = 5'd5;
    tick();
    clear_inputs();
    tick();
    check("rstmid_grant", bus.rf_read, 4'b0001);
    tick();
    rst = 1'b1;
    #1;
    r6 = {bus.wr_req_ready, bus.rd_req_ready};
    check("rstmid_ready", r6, 6'b0);
    check("rstmid_rf_read", bus.rf_read, 4'b0);
    tick();
    r6 = {bus.wr_req_ready, bus.rd_req_ready};
    check("rstmid_ready2", r6, 6'b0);
    rst = 1'b0;
    exp_rd_addr = '0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rstmid_no_rsp", bus.rd_rsp_valid, 4'b0);
    end
    check_fields("rstmid");
    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
